tmds_word_align: RTL

- Per-channel receive-side word aligner for the TMDS/HDMI input path. It is the counterpart of the 10:1 output serializer.
- Takes raw 10-bit words from a 1:10 ISERDES running on PixelClk. Drives the ISERDES bitslip until the word boundary matches the transmitter, using TMDS control tokens seen during blanking.
- Reports lock and error status, and forwards the aligned word to the TMDS decoder.

---
 rtl/tmds_pkg.sv | 13 +
 rtl/tmds_token_detect.sv | 16 +
 rtl/tmds_word_align.sv | 116 +++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens and word-aligner states shared across the TMDS receive path
package tmds_pkg;
    localparam logic [9:0] kCtlToken0 = 10'h354;
    localparam logic [9:0] kCtlToken1 = 10'h0AB;
    localparam logic [9:0] kCtlToken2 = 10'h154;
    localparam logic [9:0] kCtlToken3 = 10'h2AB;

    typedef enum logic [2:0] {SEARCH, SLIP, SETTLE, ERROR, LOCKED} alignState_t;

    function automatic logic isCtlToken(input logic [9:0] word);
        return word == kCtlToken0 || word == kCtlToken1 || word == kCtlToken2 || word == kCtlToken3;
    endfunction
endpackage

// File: rtl/tmds_token_detect.sv
// tmds_token_detect: registers the raw TMDS word and flags the four control tokens
module tmds_token_detect
    import tmds_pkg::*;
(
    input  logic       PixelClk,
    input  logic       aRst_n,
    input  logic [9:0] pRawWord,
    output logic [9:0] pDataOut,
    output logic       pIsToken
);
    always_ff @(posedge PixelClk or negedge aRst_n)
        if (!aRst_n) pDataOut <= '0;
        else pDataOut <= pRawWord;

    assign pIsToken = isCtlToken(pDataOut);
endmodule

// File: rtl/tmds_word_align.sv
// tmds_word_align: slips the ISERDES word boundary until blanking tokens line up, then holds lock
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int kTokenCount    = 128,
    parameter int kSearchTimeout = 1048576,
    parameter int kSettleCycles  = 3,
    parameter int kMaxSlips      = 10,
    parameter int kLossTimeout   = 1048576
) (
    input  logic       PixelClk,
    input  logic       aRst_n,
    input  logic [9:0] pRawWord,
    input  logic       pRetrain,
    output logic       pBitslip,
    output logic [9:0] pDataOut,
    output logic       pAligned,
    output logic       pAlignErr,
    output logic [3:0] pSlipCount
);
    localparam int kRunW     = $clog2(kTokenCount + 1);
    localparam int kTimeoutW = $clog2(kSearchTimeout + 1);
    localparam int kSettleW  = $clog2(kSettleCycles + 1);
    localparam int kLossW    = $clog2(kLossTimeout + 1);
    localparam logic [kRunW-1:0]     kRunLock     = kRunW'(kTokenCount);
    localparam logic [kTimeoutW-1:0] kTimeoutLast = kTimeoutW'(kSearchTimeout - 1);
    localparam logic [kSettleW-1:0]  kSettleLast  = kSettleW'(kSettleCycles - 1);
    localparam logic [kLossW-1:0]    kLossLast    = kLossW'(kLossTimeout - 1);
    localparam logic [3:0]           kSlipLimit   = 4'(kMaxSlips);

    alignState_t          state;
    logic [kRunW-1:0]     runCount;
    logic [kTimeoutW-1:0] timeoutCount;
    logic [kSettleW-1:0]  settleCount;
    logic [kLossW-1:0]    lossCount;
    logic                 isToken;

    tmds_token_detect uDetect (
        .PixelClk(PixelClk),
        .aRst_n(aRst_n),
        .pRawWord(pRawWord),
        .pDataOut(pDataOut),
        .pIsToken(isToken)
    );

    // Counters compare their registered value, so every decision lags the detect flag by one cycle.
    always_ff @(posedge PixelClk or negedge aRst_n) begin
        if (!aRst_n) begin
            state        <= SEARCH;
            runCount     <= '0;
            timeoutCount <= '0;
            settleCount  <= '0;
            lossCount    <= '0;
            pBitslip     <= 1'b0;
            pAligned     <= 1'b0;
            pAlignErr    <= 1'b0;
            pSlipCount   <= '0;
        end else if (pRetrain) begin
            state        <= SEARCH;
            runCount     <= '0;
            timeoutCount <= '0;
            lossCount    <= '0;
            pBitslip     <= 1'b0;
            pAligned     <= 1'b0;
        end else begin
            pBitslip <= 1'b0;
            case (state)
                SEARCH:
                    if (runCount == kRunLock) begin
                        state      <= LOCKED;
                        lossCount  <= '0;
                        pAligned   <= 1'b1;
                        pAlignErr  <= 1'b0;
                        pSlipCount <= '0;
                    end else if (timeoutCount == kTimeoutLast) begin
                        state      <= SLIP;
                        pBitslip   <= 1'b1;
                        pSlipCount <= (pSlipCount < kSlipLimit) ? pSlipCount + 4'd1 : pSlipCount;
                    end else begin
                        timeoutCount <= timeoutCount + 1'b1;
                        runCount     <= isToken ? runCount + 1'b1 : '0;
                    end
                SLIP: begin
                    state       <= (pSlipCount >= kSlipLimit) ? ERROR : SETTLE;
                    settleCount <= '0;
                end
                ERROR: begin
                    state       <= SETTLE;
                    settleCount <= '0;
                    pAlignErr   <= 1'b1;
                    pSlipCount  <= '0;
                end
                SETTLE:
                    if (settleCount == kSettleLast) begin
                        state        <= SEARCH;
                        runCount     <= '0;
                        timeoutCount <= '0;
                    end else begin
                        settleCount <= settleCount + 1'b1;
                    end
                LOCKED:
                    if (isToken) begin
                        lossCount <= '0;
                    end else if (lossCount == kLossLast) begin
                        state        <= SEARCH;
                        runCount     <= '0;
                        timeoutCount <= '0;
                        pAligned     <= 1'b0;
                    end else begin
                        lossCount <= lossCount + 1'b1;
                    end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule
